// File: rtl/data_mem_rd_deserialise_if.sv
// Bundles the serial memory pins and the CPU-side read strobe/word of the
// read deserialiser; master = requester/memory side, slave = deserialiser.
interface data_mem_rd_deserialise_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  rd_start;
   logic                  rd_abort;
   logic                  data_mem_data_stream;
   logic                  data_mem_rd_en;
   logic                  busy;
   logic                  rd_valid;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_parity_err;

   modport master (
      output rd_start, rd_abort, data_mem_data_stream,
      input  data_mem_rd_en, busy, rd_valid, rd_data, rd_parity_err
   );

   modport slave (
      input  rd_start, rd_abort, data_mem_data_stream,
      output data_mem_rd_en, busy, rd_valid, rd_data, rd_parity_err
   );
endinterface

// File: rtl/data_mem_rd_deserialise.sv
// Serial data-memory read deserialiser: turnaround wait, MSB-first shift-in,
// one-cycle rd_valid. Define DATA_MEM_PARITY_EN for a trailing even-parity bit.
//
// state    | meaning
// ST_IDLE  | waiting for rd_start
// ST_WAIT  | turnaround down-counter running, stream not sampled
// ST_SHIFT | one data bit sampled per cycle, MSB first
// ST_PARITY| parity bit sampled (DATA_MEM_PARITY_EN only)
// ST_DONE  | rd_valid high for one cycle, rd_data freshly loaded
module data_mem_rd_deserialise #(
   parameter int DATA_WIDTH = 8,
   parameter int TURNAROUND = 2
) (
   input logic                      sys_clk,
   input logic                      sys_reset_n,
   data_mem_rd_deserialise_if.slave bus
);

   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_SHIFT  = 3'd2,
`ifdef DATA_MEM_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_DONE   = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            tcnt_q, tcnt_d;
   logic [CNT_W-1:0]      bcnt_q, bcnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  perr_q, perr_d;

   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         state_q   <= ST_IDLE;
         tcnt_q    <= '0;
         bcnt_q    <= '0;
         shift_q   <= '0;
         rd_data_q <= '0;
         perr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tcnt_q    <= tcnt_d;
         bcnt_q    <= bcnt_d;
         shift_q   <= shift_d;
         rd_data_q <= rd_data_d;
         perr_q    <= perr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      tcnt_d    = tcnt_q;
      bcnt_d    = bcnt_q;
      shift_d   = shift_q;
      rd_data_d = rd_data_q;
      perr_d    = perr_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.rd_start) begin
               tcnt_d  = 4'(TURNAROUND);
               bcnt_d  = '0;
               state_d = (TURNAROUND == 0) ? ST_SHIFT : ST_WAIT;
            end
         end
         ST_WAIT: begin
            tcnt_d = tcnt_q - 4'd1;
            if (tcnt_q == 4'd1) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            shift_d = {shift_q[DATA_WIDTH-2:0], bus.data_mem_data_stream};
            bcnt_d  = bcnt_q + CNT_W'(1);
            if (bcnt_q == LAST_BIT) begin
`ifdef DATA_MEM_PARITY_EN
               state_d = ST_PARITY;
`else
               state_d   = ST_DONE;
               rd_data_d = shift_d;
`endif
            end
         end
`ifdef DATA_MEM_PARITY_EN
         ST_PARITY: begin
            state_d   = ST_DONE;
            rd_data_d = shift_q;
            perr_d    = ^{shift_q, bus.data_mem_data_stream};
         end
`endif
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Abort wins over everything, including a same-cycle rd_start or word completion.
      if (bus.rd_abort) begin
         state_d   = ST_IDLE;
         tcnt_d    = '0;
         bcnt_d    = '0;
         shift_d   = '0;
         rd_data_d = rd_data_q;
         perr_d    = perr_q;
      end
   end

`ifdef DATA_MEM_PARITY_EN
   assign bus.data_mem_rd_en = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
   assign bus.busy           = (state_q == ST_WAIT) || (state_q == ST_SHIFT) ||
                               (state_q == ST_PARITY);
   assign bus.rd_parity_err  = perr_q;
`else
   assign bus.data_mem_rd_en = (state_q == ST_SHIFT);
   assign bus.busy           = (state_q == ST_WAIT) || (state_q == ST_SHIFT);
   assign bus.rd_parity_err  = 1'b0;
`endif
   assign bus.rd_valid = (state_q == ST_DONE);
   assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_data_mem_rd_deserialise.sv
// Directed bench for data_mem_rd_deserialise: two instances (TURNAROUND 2 and 0)
// share stimulus; expected cycle timing and words are computed by the bench.
module tb_data_mem_rd_deserialise;

   localparam int W = 8;
`ifdef DATA_MEM_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic sys_clk = 1'b0;
   logic sys_reset_n = 1'b1;
   logic rd_start = 1'b0;
   logic rd_abort = 1'b0;
   logic stream = 1'b0;
   logic use_ta0 = 1'b0;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   logic [W-1:0] exp_data = '0;
   logic         exp_perr = 1'b0;

   always #5 sys_clk = ~sys_clk;

   data_mem_rd_deserialise_if #(.DATA_WIDTH(W)) if2 ();
   data_mem_rd_deserialise_if #(.DATA_WIDTH(W)) if0 ();

   assign if2.rd_start = rd_start;
   assign if2.rd_abort = rd_abort;
   assign if2.data_mem_data_stream = stream;
   assign if0.rd_start = rd_start;
   assign if0.rd_abort = rd_abort;
   assign if0.data_mem_data_stream = stream;

   data_mem_rd_deserialise #(.DATA_WIDTH(W), .TURNAROUND(2)) dut2 (
      .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .bus(if2));
   data_mem_rd_deserialise #(.DATA_WIDTH(W), .TURNAROUND(0)) dut0 (
      .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .bus(if0));

   logic         o_busy, o_rden, o_valid, o_perr;
   logic [W-1:0] o_data;
   always_comb begin
      o_busy  = use_ta0 ? if0.busy : if2.busy;
      o_rden  = use_ta0 ? if0.data_mem_rd_en : if2.data_mem_rd_en;
      o_valid = use_ta0 ? if0.rd_valid : if2.rd_valid;
      o_perr  = use_ta0 ? if0.rd_parity_err : if2.rd_parity_err;
      o_data  = use_ta0 ? if0.rd_data : if2.rd_data;
   end

   task automatic step();
      @(posedge sys_clk);
      #1;
      cyc++;
   endtask

   // Starts a read in the current cycle (cycle 0) and checks every cycle up to
   // the rd_valid cycle, or one past it when the read is aborted.
   task automatic read_word(input string name, input int ta, input logic [W-1:0] word,
                            input logic pbit, input int abort_at, input int dup_at);
      int  last_bit;
      int  vcyc;
      int  endc;
      bit  ab;
      logic e_busy, e_rden, e_valid;
      last_bit = ta + W + P;
      vcyc     = last_bit + 1;
      endc     = (abort_at >= 0) ? vcyc + 1 : vcyc;
      rd_start = 1'b1;
      rd_abort = 1'b0;
      for (int c = 1; c <= endc; c++) begin
         step();
         rd_start = (c == dup_at);
         rd_abort = (c == abort_at);
         if (c >= ta + 1 && c <= ta + W) stream = word[W-1-(c-ta-1)];
         else if (P == 1 && c == ta + W + 1) stream = pbit;
         else stream = c[0];
         ab      = (abort_at >= 0) && (c > abort_at);
         e_busy  = !ab && (c <= last_bit);
         e_rden  = !ab && (c >= ta + 1) && (c <= last_bit);
         e_valid = !ab && (c == vcyc);
         if (e_valid) begin
            exp_data = word;
            if (P == 1) exp_perr = (^word) ^ pbit;
         end
         n_checks += 5;
         if (o_busy !== e_busy) begin
            n_fail++;
            $display("FAIL %s busy c%0d got %b exp %b", name, c, o_busy, e_busy);
         end
         if (o_rden !== e_rden) begin
            n_fail++;
            $display("FAIL %s rd_en c%0d got %b exp %b", name, c, o_rden, e_rden);
         end
         if (o_valid !== e_valid) begin
            n_fail++;
            $display("FAIL %s rd_valid c%0d got %b exp %b", name, c, o_valid, e_valid);
         end
         if (o_data !== exp_data) begin
            n_fail++;
            $display("FAIL %s rd_data c%0d got %h exp %h", name, c, o_data, exp_data);
         end
         if (o_perr !== exp_perr) begin
            n_fail++;
            $display("FAIL %s parity_err c%0d got %b exp %b", name, c, o_perr, exp_perr);
         end
      end
      rd_start = 1'b0;
      rd_abort = 1'b0;
   endtask

   task automatic test_reset();
      use_ta0 = 1'b0;
      #2 sys_reset_n = 1'b0;
      step();
      step();
      n_checks += 5;
      if (o_busy !== 1'b0 || o_rden !== 1'b0 || o_valid !== 1'b0 ||
          o_data !== '0 || o_perr !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state got busy%b en%b v%b d%h pe%b exp all 0",
                  o_busy, o_rden, o_valid, o_data, o_perr);
      end
      sys_reset_n = 1'b1;
      step();
      exp_data = '0;
      exp_perr = 1'b0;
      read_word("pre_reset_read", 2, 8'hC3, 1'b1, -1, -1);
      step();
      // Second read interrupted by reset in the middle of SHIFT.
      rd_start = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         step();
         rd_start = 1'b0;
         stream = c[0];
      end
      n_checks++;
      if (o_rden !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_shift rd_en got %b exp 1", o_rden);
      end
      #2 sys_reset_n = 1'b0;
      #1;
      n_checks += 5;
      if (o_busy !== 1'b0 || o_rden !== 1'b0 || o_valid !== 1'b0 ||
          o_data !== '0 || o_perr !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset got busy%b en%b v%b d%h pe%b exp all 0",
                  o_busy, o_rden, o_valid, o_data, o_perr);
      end
      exp_data = '0;
      exp_perr = 1'b0;
      step();
      sys_reset_n = 1'b1;
      step();
      read_word("read_a5", 2, 8'hA5, 1'b0, -1, -1);
   endtask

   task automatic test_ignore_start();
      step();
      read_word("dup_start", 2, 8'hA5, 1'b0, -1, 5);
      rd_start = 1'b1;
      step();
      rd_start = 1'b0;
      n_checks += 2;
      if (o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL start_in_done busy got %b exp 0", o_busy);
      end
      if (o_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL start_in_done rd_valid got %b exp 0", o_valid);
      end
      read_word("start_after_done", 2, 8'h5A, 1'b1, -1, -1);
   endtask

   task automatic test_abort();
      step();
      read_word("aborted", 2, 8'h99, 1'b1, 6, -1);
      read_word("after_abort", 2, 8'hFF, 1'b0, -1, -1);
      step();
      rd_start = 1'b1;
      rd_abort = 1'b1;
      step();
      rd_start = 1'b0;
      rd_abort = 1'b0;
      n_checks++;
      if (o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_over_start busy got %b exp 0", o_busy);
      end
   endtask

   task automatic test_back_to_back();
      int v1;
      int v2;
      step();
      read_word("b2b_first", 2, 8'h01, 1'b1, -1, -1);
      v1 = cyc;
      step();
      read_word("b2b_second", 2, 8'h80, 1'b1, -1, -1);
      v2 = cyc;
      n_checks++;
      if (v2 - v1 != 12 + P) begin
         n_fail++;
         $display("FAIL b2b_spacing got %0d exp %0d", v2 - v1, 12 + P);
      end
   endtask

   task automatic test_ta0();
      use_ta0 = 1'b1;
      sys_reset_n = 1'b0;
      step();
      sys_reset_n = 1'b1;
      exp_data = '0;
      exp_perr = 1'b0;
      step();
      read_word("ta0_3c", 0, 8'h3C, 1'b0, -1, -1);
      step();
      read_word("ta0_c7", 0, 8'hC7, 1'b0, -1, -1);
      use_ta0 = 1'b0;
   endtask

`ifdef DATA_MEM_PARITY_EN
   task automatic test_parity();
      use_ta0 = 1'b0;
      step();
      step();
      read_word("par_ok", 2, 8'hA5, 1'b0, -1, -1);
      step();
      read_word("par_bad", 2, 8'hA5, 1'b1, -1, -1);
      step();
      read_word("par_abort", 2, 8'h0F, 1'b0, 11, -1);
   endtask
`endif

   initial begin
      test_reset();
      test_ignore_start();
      test_abort();
      test_back_to_back();
      test_ta0();
`ifdef DATA_MEM_PARITY_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/data_mem_rd_deserialise.md
Name: data_mem_rd_deserialise

Overview:
- Downstream companion of the serial data-memory address sender.
- Once the address has been shifted out, this block waits a fixed turnaround and shifts in one DATA_WIDTH-bit read word, MSB first, from the external serial data line.
- It then presents the word to the CPU datapath with a one-cycle valid strobe.
- Sits between the chip's serial memory input pin and the CPU load path.

Parameters:
- DATA_WIDTH, 8: width of the read word and number of serial bits shifted in.
- TURNAROUND, 2: cycles between rd_start and the first sampled bit, minus one. Legal range 0..15.

Ports:
- sys_clk  input  1  system clock; all state changes on its rising edge.
- sys_reset_n  input  1  asynchronous, active-low reset.
- rd_start  input  1  one-cycle pulse: address serialisation finished, begin read.
- rd_abort  input  1  synchronous abort: return to IDLE, no valid issued.
- data_mem_data_stream  input  1  serial read data from memory, MSB first.
- data_mem_rd_en  output  1  high in every cycle in which a data bit is sampled.
- busy  output  1  high while a read is in progress (WAIT, SHIFT, PARITY states).
- rd_valid  output  1  one-cycle pulse: rd_data holds a newly completed word.
- rd_data  output  DATA_WIDTH  last completed read word; held between reads.
- rd_parity_err  output  1  parity error flag for the word qualified by rd_valid.

Behaviour:
- Reset (asynchronous, sys_reset_n=0):
  - state=IDLE; shift register, bit counter and turnaround counter cleared.
  - rd_data=0, rd_valid=0, rd_parity_err=0, busy=0, data_mem_rd_en=0.
- States: IDLE, WAIT, SHIFT, (PARITY only with the optional feature), DONE.
- IDLE:
  - rd_start=1 -> WAIT with turnaround counter loaded to TURNAROUND.
  - If TURNAROUND=0, go directly to SHIFT.
  - Other inputs are ignored.
- WAIT:
  - Counter decrements each cycle; stream is not sampled.
  - When the counter reaches 1 (after TURNAROUND cycles in WAIT) -> SHIFT.
- SHIFT:
  - data_mem_rd_en=1 (combinational decode of state).
  - Each cycle: shift register <= {shift[DATA_WIDTH-2:0], data_mem_data_stream}; bit counter increments.
  - After the DATA_WIDTH-th sample -> DONE (or PARITY with the optional feature).
  - The bit counter is $clog2(DATA_WIDTH)+1 bits wide; no wrap-around occurs within a word.
- DONE (single cycle):
  - rd_valid=1; rd_data is loaded with the shift register on entry, so it is valid in the same cycle rd_valid is high.
  - Next state: IDLE.
- Latency: with rd_start at cycle 0, bits are sampled on cycles TURNAROUND+1 .. TURNAROUND+DATA_WIDTH, and rd_valid is high in cycle TURNAROUND+DATA_WIDTH+1.
- busy: high in WAIT, SHIFT and PARITY; low in IDLE and DONE.
- Boundary conditions:
  - rd_start while busy or in DONE: ignored; no queuing.
  - rd_abort=1 in any state: next state IDLE. It overrides rd_start in the same cycle. rd_valid is not issued, rd_data is unchanged, and the partial word is discarded.
  - Reset mid-read: immediate IDLE, all outputs at their reset values.
  - rd_data changes only when entering DONE.

Optional Feature:
- Macro: DATA_MEM_PARITY_EN.
- Defined:
  - After the LSB, state PARITY samples one extra bit with data_mem_rd_en=1.
  - Even parity: XOR of the DATA_WIDTH data bits and the parity bit must be 0.
  - rd_parity_err is registered, set in DONE alongside rd_valid to 1 on mismatch and 0 otherwise, and held until the next DONE.
  - Latency grows by one cycle: rd_valid in cycle TURNAROUND+DATA_WIDTH+2.
  - Abort in PARITY behaves as in the other states.
- Not defined:
  - PARITY state is absent.
  - rd_parity_err is tied to 0; the port remains for interface stability.

Test Plan:
- Reset with sys_reset_n=0 mid-SHIFT -> outputs 0 immediately, asynchronously. After release, rd_start; stream 0xA5 MSB first (1,0,1,0,0,1,0,1) on cycles 3..10 -> rd_valid only in cycle 11, rd_data=0xA5, busy high cycles 1..10.
- TURNAROUND=0, stream 0x3C -> data_mem_rd_en high cycles 1..8, rd_valid in cycle 9, rd_data=0x3C.
- rd_start pulsed again in cycle 5 of a read -> ignored: one rd_valid, word 0xA5 intact. Then rd_start in the DONE cycle -> ignored; rd_start one cycle later -> accepted.
- Read 0x5A completes; new read aborted at cycle 6 -> no rd_valid, rd_data stays 0x5A, busy=0 from cycle 7; next full read of 0xFF -> rd_data=0xFF.
- Back-to-back reads 0x01 then 0x80 with rd_start on the cycle after each DONE -> two rd_valid pulses 12 cycles apart, correct words.
- With DATA_MEM_PARITY_EN: word 0xA5 + parity bit 0 -> rd_valid in cycle 12, rd_parity_err=0. Parity bit 1 -> rd_parity_err=1, held through a following aborted read.
